sram_bist_sched: RTL and testbench
==================================

Name: sram_bist_sched

Overview:
Sequences built-in self-test across NUM_BANKS instances of the bist_sram bank wrapper. Tests run one bank at a time. The block drives each bank's bist_en, waits for that bank's b_done/b_fail, and enforces a per-bank timeout. It collects per-bank pass/fail status and holds busy high so the AHB-side front end stalls host SRAM traffic while any bank is under test.

Parameters:
NUM_BANKS, 4, number of SRAM banks sequenced (1..16)
TIMEOUT, 200000, maximum cycles a bank may stay in RUN before it is declared timed out (>=2)
AUTO_START, 1, 1 = run a full-mask sequence automatically after reset release
IDX_W, $clog2(NUM_BANKS) (min 1), bank index width (derived)
TO_W, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
sram_clk  input  1  clock, shared with all banks
sram_rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sequence; honoured only in IDLE
abort  input  1  level; ends the current sequence early
bank_mask  input  NUM_BANKS  banks to test, sampled when start is accepted
bist_en_o  output  NUM_BANKS  per-bank bist_en; at most one bit high
b_done_i  input  NUM_BANKS  per-bank b_done
b_fail_i  input  NUM_BANKS  per-bank b_fail
busy  output  1  sequence in progress; host access blocked
done  output  1  one-cycle pulse when a sequence ends
pass  output  1  last sequence completed with no failure, no timeout and no abort
aborted  output  1  last sequence was ended by abort
fail_map  output  NUM_BANKS  per-bank failure (b_fail or timeout), last sequence
timeout_map  output  NUM_BANKS  per-bank timeout, last sequence

Behaviour:
- One clock, sram_clk. Reset is asynchronous, active-low, on sram_rst_n. All registers are rising-edge.
- Reset values: all outputs 0. State=IDLE, idx=0, tmo_cnt=0, latched mask=0.
- States: IDLE, SCAN, RUN, GAP, FINISH.
- IDLE:
  - AUTO_START=1: on the first edge after reset release, load mask=all ones and go to SCAN.
  - Otherwise: start=1 loads mask=bank_mask, idx=0, clears fail_map/timeout_map/pass/aborted, and goes to SCAN. busy=1 from the next cycle.
  - start is ignored in every state other than IDLE.
- SCAN (1 cycle per bank index):
  - mask[idx]=1 -> RUN, tmo_cnt=0.
  - mask[idx]=0 and idx==NUM_BANKS-1 -> FINISH.
  - Otherwise idx+1 and stay in SCAN.
  - mask==0 therefore reaches FINISH after NUM_BANKS SCAN cycles, with pass=1.
- RUN:
  - bist_en_o[idx]=1, registered: high on the first RUN cycle. tmo_cnt increments every cycle.
  - b_done_i[idx]=1 -> fail_map[idx]<=b_fail_i[idx], go to GAP. bist_en_o drops in the GAP cycle.
  - No done and tmo_cnt==TIMEOUT-1 -> fail_map[idx]<=1, timeout_map[idx]<=1, go to GAP. The bank is held in RUN for exactly TIMEOUT cycles.
  - Done and timeout in the same cycle: done wins, no timeout flag.
  - b_done_i/b_fail_i of banks other than idx are ignored in all states.
- GAP (1 cycle, all bist_en_o=0, lets the bank's BIST engine return to idle):
  - idx==NUM_BANKS-1 -> FINISH.
  - Otherwise idx+1 and go to SCAN.
- FINISH (1 cycle):
  - done=1 and pass<=~|fail_map & ~aborted. busy stays high this cycle.
  - Next state IDLE; busy=0, idx=0.
- abort=1 in SCAN/RUN/GAP:
  - Next cycle: all bist_en_o=0, aborted<=1, go to FINISH.
  - The in-flight bank's fail_map bit is left unchanged; pass=0.
  - abort in IDLE or FINISH is ignored.
- Status (fail_map, timeout_map, pass, aborted) holds until the next accepted start.
- Invariant: bist_en_o is one-hot or zero at all times; it is zero in IDLE, SCAN, GAP and FINISH.
- Reset mid-sequence: all outputs drop to 0 immediately, asynchronously. With AUTO_START=1 the sequence restarts from bank 0.

Test Plan:
- AUTO_START=1, NUM_BANKS=4, bank BFMs return done after 50 cycles with fail=0 -> banks 0..3 enabled in order, one GAP cycle between them, single done pulse, pass=1, fail_map=0000.
- AUTO_START=0, start with bank_mask=4'b1010, bank 3 returns fail=1 -> only bist_en_o[1] and [3] ever assert, fail_map=1000, pass=0, done asserts exactly once.
- TIMEOUT=16, bank 2 never returns done -> bist_en_o[2] high exactly 16 cycles, timeout_map=0100, fail_map=0100, sequence continues to bank 3, pass=0.
- abort asserted 10 cycles into bank 1 RUN -> next cycle all enables are 0, then done pulse, aborted=1, pass=0, fail_map[1] unchanged; a start pulse during the run is ignored.
- bank_mask=0 -> no enable ever asserts, done pulse follows NUM_BANKS SCAN cycles, pass=1.
- sram_rst_n asserted mid-RUN of bank 2 -> busy and all enables are 0 with no clock edge; after release (AUTO_START=1) the sequence restarts at bank 0.

Source files
------------

// File: rtl/sram_bist_sched.sv
// Runs BIST on SRAM banks one at a time with a per-bank timeout, and
// collects per-bank pass/fail and timeout status for the last sequence.

module sram_bist_slot (
  input  logic sram_clk,
  input  logic sram_rst_n,
  input  logic clr_i,
  input  logic sel_i,
  input  logic run_nxt_i,
  input  logic cap_i,
  input  logic to_i,
  input  logic b_fail_i,
  output logic en_o,
  output logic fail_o,
  output logic tmo_o
);
  logic en_q, fail_q, tmo_q;

  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      en_q   <= 1'b0;
      fail_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      en_q <= sel_i & run_nxt_i;
      if (clr_i) begin
        fail_q <= 1'b0;
        tmo_q  <= 1'b0;
      end else if (sel_i && cap_i) begin
        fail_q <= to_i | b_fail_i;
        tmo_q  <= to_i;
      end
    end
  end

  assign en_o   = en_q;
  assign fail_o = fail_q;
  assign tmo_o  = tmo_q;
endmodule

module sram_bist_sched #(
  parameter int NUM_BANKS  = 4,
  parameter int TIMEOUT    = 200000,
  parameter int AUTO_START = 1
) (
  input  logic                 sram_clk,
  input  logic                 sram_rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_BANKS-1:0] bank_mask,
  output logic [NUM_BANKS-1:0] bist_en_o,
  input  logic [NUM_BANKS-1:0] b_done_i,
  input  logic [NUM_BANKS-1:0] b_fail_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 aborted,
  output logic [NUM_BANKS-1:0] fail_map,
  output logic [NUM_BANKS-1:0] timeout_map
);
  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BANKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_RUN, S_GAP, S_FINISH} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TO_W-1:0]       tmo_q, tmo_d;
  logic [NUM_BANKS-1:0]  mask_q, mask_d;
  logic                  auto_q, auto_d;
  logic                  pass_q, pass_d;
  logic                  abrt_q, abrt_d;
  logic                  clr, cap, to;

  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      mask_q  <= '0;
      auto_q  <= (AUTO_START != 0);
      pass_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      mask_q  <= mask_d;
      auto_q  <= auto_d;
      pass_q  <= pass_d;
      abrt_q  <= abrt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    mask_d  = mask_q;
    auto_d  = auto_q;
    pass_d  = pass_q;
    abrt_d  = abrt_q;
    clr     = 1'b0;
    cap     = 1'b0;
    to      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The post-reset auto run behaves like a start with a full mask.
        if (auto_q || start) begin
          mask_d  = auto_q ? '1 : bank_mask;
          auto_d  = 1'b0;
          idx_d   = '0;
          pass_d  = 1'b0;
          abrt_d  = 1'b0;
          clr     = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          abrt_d  = 1'b1;
          state_d = S_FINISH;
        end else if (mask_q[idx_q]) begin
          tmo_d   = '0;
          state_d = S_RUN;
        end else if (idx_q == LAST) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RUN: begin
        tmo_d = tmo_q + 1'b1;
        if (abort) begin
          abrt_d  = 1'b1;
          state_d = S_FINISH;
        end else if (b_done_i[idx_q]) begin
          cap     = 1'b1;
          state_d = S_GAP;
        end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
          cap     = 1'b1;
          to      = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (abort) begin
          abrt_d  = 1'b1;
          state_d = S_FINISH;
        end else if (idx_q == LAST) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SCAN;
        end
      end
      S_FINISH: begin
        pass_d  = ~|fail_map & ~abrt_q;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_slot
    sram_bist_slot u_slot (
      .sram_clk   (sram_clk),
      .sram_rst_n (sram_rst_n),
      .clr_i      (clr),
      .sel_i      (idx_q == IDX_W'(b)),
      .run_nxt_i  (state_d == S_RUN),
      .cap_i      (cap),
      .to_i       (to),
      .b_fail_i   (b_fail_i[b]),
      .en_o       (bist_en_o[b]),
      .fail_o     (fail_map[b]),
      .tmo_o      (timeout_map[b])
    );
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FINISH);
  assign pass    = pass_q;
  assign aborted = abrt_q;
endmodule

// File: tb/tb_sram_bist_sched.sv
// Directed + randomized bench for sram_bist_sched: bank BFMs with per-bank
// latency/fail settings, a monitor, and a sequence-level expected-result model.

module tb_sram_bist_sched;
  localparam int NB = 4;
  localparam int TO = 64;
  localparam int NEVER = 1000;

  logic          sram_clk = 1'b0;
  logic          sram_rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NB-1:0] bank_mask = '0;
  logic [NB-1:0] b_done_i = '0;
  logic [NB-1:0] b_fail_i = '0;
  logic [NB-1:0] bist_en_o, fail_map, timeout_map;
  logic          busy, done, pass, aborted;

  int n_cmp = 0;
  int n_bad = 0;

  int lat[NB];
  bit flt[NB];

  int en_cnt[NB], dur[NB];
  int order[$], gaps[$];
  int busy_cnt, done_cnt, multi_en, low_run;
  bit have_prev;

  int            exp_dur[NB];
  int            exp_order[$], exp_gaps[$];
  logic [NB-1:0] exp_fail, exp_tmo;
  int            exp_busy;
  logic          exp_pass;

  sram_bist_sched #(.NUM_BANKS(NB), .TIMEOUT(TO), .AUTO_START(1)) dut (
    .sram_clk    (sram_clk),
    .sram_rst_n  (sram_rst_n),
    .start       (start),
    .abort       (abort),
    .bank_mask   (bank_mask),
    .bist_en_o   (bist_en_o),
    .b_done_i    (b_done_i),
    .b_fail_i    (b_fail_i),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .aborted     (aborted),
    .fail_map    (fail_map),
    .timeout_map (timeout_map)
  );

  always #5 sram_clk = ~sram_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    order.delete();
    gaps.delete();
    busy_cnt = 0; done_cnt = 0; multi_en = 0; low_run = 0; have_prev = 0;
    for (int b = 0; b < NB; b++) begin en_cnt[b] = 0; dur[b] = 0; end
  endtask

  // One clock: sample outputs at the falling edge, then drive bank responses.
  task automatic tick();
    logic [NB-1:0] en;
    @(negedge sram_clk);
    en = bist_en_o;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if ($countones(en) > 1) multi_en++;
    if (en == '0) low_run++;
    for (int b = 0; b < NB; b++) begin
      if (en[b]) begin
        if (en_cnt[b] == 0) begin
          order.push_back(b);
          if (have_prev) gaps.push_back(low_run);
          have_prev = 1'b1;
          low_run = 0;
        end
        en_cnt[b]++;
      end else if (en_cnt[b] != 0) begin
        dur[b] = en_cnt[b];
        en_cnt[b] = 0;
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (en[b]) begin
        b_done_i[b] = (en_cnt[b] == lat[b]);
        b_fail_i[b] = (en_cnt[b] == lat[b]) ? flt[b] : 1'($urandom_range(0, 1));
      end else begin
        b_done_i[b] = sram_rst_n ? 1'($urandom_range(0, 1)) : 1'b0;
        b_fail_i[b] = sram_rst_n ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  // Expected sequence outcome from the bank settings: each masked bank is
  // enabled for min(latency, TO) cycles; a bank that never answers in time fails.
  task automatic model(input logic [NB-1:0] m);
    int prev, sum;
    exp_order.delete();
    exp_gaps.delete();
    exp_fail = '0; exp_tmo = '0; prev = -1; sum = 0;
    for (int b = 0; b < NB; b++) begin
      exp_dur[b] = 0;
      if (m[b]) begin
        exp_dur[b] = (lat[b] <= TO) ? lat[b] : TO;
        if (lat[b] <= TO) exp_fail[b] = flt[b];
        else begin exp_fail[b] = 1'b1; exp_tmo[b] = 1'b1; end
        sum += exp_dur[b] + 1;
        exp_order.push_back(b);
        if (prev >= 0) exp_gaps.push_back(b - prev + 1);
        prev = b;
      end
    end
    exp_busy = NB + sum + 1;
    exp_pass = (exp_fail == '0);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < NB * (TO + 3) + 20) begin tick(); k++; end
    chk({nm, ".done_seen"}, done, 1);
    chk({nm, ".en_in_finish"}, bist_en_o, 0);
  endtask

  task automatic do_seq(input logic [NB-1:0] m, input bit use_start, input string nm);
    model(m);
    clear_mon();
    if (use_start) begin
      start = 1'b1; bank_mask = m;
      tick();
      start = 1'b0; bank_mask = ~m;
    end
    wait_done(nm);
    tick();
    chk({nm, ".done_once"}, done_cnt, 1);
    chk({nm, ".busy_off"}, busy, 0);
    chk({nm, ".busy_cycles"}, busy_cnt, exp_busy);
    chk({nm, ".pass"}, pass, exp_pass);
    chk({nm, ".aborted"}, aborted, 0);
    chk({nm, ".fail_map"}, fail_map, exp_fail);
    chk({nm, ".timeout_map"}, timeout_map, exp_tmo);
    chk({nm, ".onehot"}, multi_en, 0);
    chk({nm, ".order_len"}, order.size(), exp_order.size());
    for (int i = 0; i < order.size() && i < exp_order.size(); i++)
      chk({nm, ".order"}, order[i], exp_order[i]);
    for (int i = 0; i < gaps.size() && i < exp_gaps.size(); i++)
      chk({nm, ".gap"}, gaps[i], exp_gaps[i]);
    for (int b = 0; b < NB; b++) chk({nm, ".en_cycles"}, dur[b], exp_dur[b]);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".pass"}, pass, 0);
    chk({nm, ".aborted"}, aborted, 0);
    chk({nm, ".en"}, bist_en_o, 0);
    chk({nm, ".fail_map"}, fail_map, 0);
    chk({nm, ".timeout_map"}, timeout_map, 0);
  endtask

  initial begin
    int k;
    logic [NB-1:0] m;

    // Reset state, then the automatic full-mask run after release.
    #3 chk_zero("reset");
    for (int b = 0; b < NB; b++) begin lat[b] = 50; flt[b] = 1'b0; end
    tick(); tick();
    sram_rst_n = 1'b1;
    do_seq('1, 1'b0, "auto");

    // Sparse mask, bank 3 reports a failure.
    for (int b = 0; b < NB; b++) begin lat[b] = $urandom_range(1, TO); flt[b] = 1'b0; end
    flt[3] = 1'b1;
    do_seq(4'b1010, 1'b1, "mask1010");

    // Bank 2 never answers; bank 3 must still run.
    for (int b = 0; b < NB; b++) begin lat[b] = $urandom_range(1, TO); flt[b] = 1'b0; end
    lat[2] = NEVER;
    do_seq(4'b1111, 1'b1, "timeout");

    // Done on the last allowed cycle wins; one cycle later is a timeout.
    lat[0] = TO; lat[1] = TO + 1; flt[0] = 1'b0;
    do_seq(4'b0011, 1'b1, "to_edge");

    // Empty mask: scan only.
    do_seq(4'b0000, 1'b1, "mask0");

    // Abort 10 cycles into bank 1, with an ignored start during the run.
    lat[0] = $urandom_range(1, 20); flt[0] = 1'($urandom_range(0, 1));
    lat[1] = NEVER;
    clear_mon();
    start = 1'b1; bank_mask = '1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; bank_mask = 4'b0100;
    tick();
    start = 1'b0;
    k = 0;
    while (!(bist_en_o[1] && en_cnt[1] == 10) && k < 200) begin tick(); k++; end
    chk("abort.reach_bank1", en_cnt[1], 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.en_off", bist_en_o, 0);
    chk("abort.done", done, 1);
    tick();
    chk("abort.done_once", done_cnt, 1);
    chk("abort.aborted", aborted, 1);
    chk("abort.pass", pass, 0);
    chk("abort.fail_map", fail_map, {3'b000, flt[0]});
    chk("abort.timeout_map", timeout_map, 0);
    chk("abort.bank1_cycles", dur[1], 10);
    chk("abort.order_len", order.size(), 2);
    chk("abort.busy_off", busy, 0);

    // Abort while idle changes nothing.
    abort = 1'b1; tick(); abort = 1'b0; tick();
    chk("idle_abort.busy", busy, 0);
    chk("idle_abort.aborted", aborted, 1);

    // Randomized sequences.
    for (int r = 0; r < 6; r++) begin
      m = NB'($urandom);
      for (int b = 0; b < NB; b++) begin
        lat[b] = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(1, TO + 2);
        flt[b] = 1'($urandom_range(0, 1));
      end
      do_seq(m, 1'b1, "rand");
    end

    // Reset during bank 2's run; the automatic run restarts at bank 0.
    for (int b = 0; b < NB; b++) begin lat[b] = 30; flt[b] = 1'b0; end
    start = 1'b1; bank_mask = '1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(bist_en_o[2] && en_cnt[2] == 5) && k < 300) begin tick(); k++; end
    chk("rst.reach_bank2", en_cnt[2], 5);
    #2 sram_rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    tick(); tick();
    sram_rst_n = 1'b1;
    do_seq('1, 1'b0, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
